// File: rtl/mux_arb_n_if.sv
// Channel bundle for mux_arb_n: producer-side valid/ready lanes plus the registered consumer port.
// Optional MUX_ARB_LOCK_EN adds the e_ultimo / s_ultimo packet-boundary signals.
interface mux_arb_n_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) ();
    logic               en;
    logic               modo;
    logic [SEL_W-1:0]   sel;
    logic [N*WIDTH-1:0] e;
    logic [N-1:0]       e_valid;
    logic [N-1:0]       e_ready;
    logic [WIDTH-1:0]   s;
    logic               s_valid;
    logic               s_ready;
    logic [SEL_W-1:0]   s_canal;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]       e_ultimo;
    logic               s_ultimo;
`endif

    modport master (
        output en, modo, sel, e, e_valid, s_ready,
`ifdef MUX_ARB_LOCK_EN
        output e_ultimo,
        input  s_ultimo,
`endif
        input  e_ready, s, s_valid, s_canal
    );

    modport slave (
        input  en, modo, sel, e, e_valid, s_ready,
`ifdef MUX_ARB_LOCK_EN
        input  e_ultimo,
        output s_ultimo,
`endif
        output e_ready, s, s_valid, s_canal
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered mux with fixed-select or round-robin arbitration and valid/ready on both sides.
// Define MUX_ARB_LOCK_EN to hold round-robin grants on one channel until its e_ultimo beat.
module mux_arb_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_arb_n_if.slave  bus
);

    logic [WIDTH-1:0] r_s;
    logic             r_s_valid;
    logic [SEL_W-1:0] r_s_canal;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load;
    logic             w_grant;
    logic [N-1:0]     w_valid_eff;
    logic [2*N-1:0]   w_rot;
    logic             w_rr_found;
    int               w_rr_off;
    int               w_rr_sum;
    logic [SEL_W-1:0] w_rr_ch;
    logic             w_fx_found;
    logic             w_cand_found;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_data;
    logic [N-1:0]     w_e_ready;

`ifdef MUX_ARB_LOCK_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_ch;
    logic             r_s_ultimo;
    logic             w_ultimo;
    logic [N-1:0]     w_lock_mask;

    always_comb begin
        w_lock_mask = '0;
        for (int i = 0; i < N; i++)
            w_lock_mask[i] = !r_lock || (r_lock_ch == SEL_W'(i));
    end

    assign w_valid_eff = bus.e_valid & w_lock_mask;
    assign bus.s_ultimo = r_s_ultimo;
`else
    assign w_valid_eff = bus.e_valid;
`endif

    assign w_load = bus.en && (!r_s_valid || bus.s_ready);

    // Round-robin: rotate the doubled request vector so bit 0 is the channel at r_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_rr_found = 1'b0;
        w_rr_off   = 0;
        w_rot      = {w_valid_eff, w_valid_eff} >> r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rr_found = 1'b1;
                w_rr_off   = k;
            end
        end
        w_rr_sum = int'(r_ptr) + w_rr_off;
        if (w_rr_sum >= N)
            w_rr_sum = w_rr_sum - N;
        w_rr_ch = SEL_W'(w_rr_sum);
    end

    // Fixed mode: a sel value outside 0..N-1 never matches, so it yields no candidate.
    always_comb begin
        w_fx_found = 1'b0;
        for (int i = 0; i < N; i++)
            if (bus.sel == SEL_W'(i) && bus.e_valid[i])
                w_fx_found = 1'b1;
    end

    assign w_cand_found = bus.modo ? w_rr_found : w_fx_found;
    assign w_cand       = bus.modo ? w_rr_ch    : bus.sel;
    assign w_grant      = rst_n && w_load && w_cand_found;
    assign w_ptr_nxt    = (w_cand == SEL_W'(N - 1)) ? '0 : w_cand + SEL_W'(1);

    always_comb begin
        w_data    = '0;
        w_e_ready = '0;
`ifdef MUX_ARB_LOCK_EN
        w_ultimo  = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (w_cand == SEL_W'(i)) begin
                w_data       = bus.e[i*WIDTH +: WIDTH];
                w_e_ready[i] = w_grant;
`ifdef MUX_ARB_LOCK_EN
                w_ultimo     = bus.e_ultimo[i];
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_s_valid <= 1'b0;
            r_s_canal <= '0;
            r_ptr     <= '0;
`ifdef MUX_ARB_LOCK_EN
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_s_ultimo <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                r_s       <= w_data;
                r_s_canal <= w_cand;
                r_s_valid <= 1'b1;
                if (bus.modo)
                    r_ptr <= w_ptr_nxt;
`ifdef MUX_ARB_LOCK_EN
                r_s_ultimo <= w_ultimo;
`endif
            end else if (w_load || bus.s_ready) begin
                // Either an empty load slot, or en=0 with the held beat being taken.
                r_s_valid <= 1'b0;
            end
`ifdef MUX_ARB_LOCK_EN
            if (!bus.modo) begin
                r_lock <= 1'b0;
            end else if (w_grant) begin
                r_lock    <= !w_ultimo;
                r_lock_ch <= w_cand;
            end
`endif
        end
    end

    assign bus.e_ready = w_e_ready;
    assign bus.s       = r_s;
    assign bus.s_valid = r_s_valid;
    assign bus.s_canal = r_s_canal;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (WIDTH=8, N=4, SEL_W=2): fixed select, round-robin, backpressure, enable, reset.
module tb_mux_arb_n;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux_arb_n_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

    mux_arb_n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ch;
        total = 0;
        bad   = 0;

        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.modo     = 1'b0;
        bus.sel      = '0;
        bus.e        = '0;
        bus.e_valid  = '0;
        bus.s_ready  = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.e_ultimo = '1;
`endif
        #12;
        check("rst_s",       32'(bus.s),       32'h00);
        check("rst_s_valid", 32'(bus.s_valid), 32'h0);
        check("rst_s_canal", 32'(bus.s_canal), 32'h0);
        check("rst_e_ready", 32'(bus.e_ready), 32'h0);
        rst_n = 1'b1;
        tick();

        // Fixed select of channel 2, then its valid drops.
        bus.modo    = 1'b0;
        bus.en      = 1'b1;
        bus.sel     = 2'd2;
        bus.e       = 32'h04_07_02_01;
        bus.e_valid = 4'b1111;
        bus.s_ready = 1'b1;
        #1;
        check("fx_e_ready", 32'(bus.e_ready), 32'b0100);
        tick();
        check("fx_s",       32'(bus.s),       32'h07);
        check("fx_s_valid", 32'(bus.s_valid), 32'h1);
        check("fx_s_canal", 32'(bus.s_canal), 32'h2);
        bus.e_valid = 4'b1011;
        #1;
        check("fx_nocand_ready", 32'(bus.e_ready), 32'h0);
        tick();
        check("fx_nocand_valid", 32'(bus.s_valid), 32'h0);
        check("fx_nocand_s",     32'(bus.s),       32'h07);

        // Round-robin over all four channels, starting from ptr=0.
        bus.modo    = 1'b1;
        bus.e       = 32'h04_03_02_01;
        bus.e_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            ch = k % 4;
            #1;
            check("rr_e_ready", 32'(bus.e_ready), 32'(1) << ch);
            tick();
            check("rr_s_canal", 32'(bus.s_canal), 32'(ch));
            check("rr_s",       32'(bus.s),       32'(ch + 1));
            check("rr_s_valid", 32'(bus.s_valid), 32'h1);
        end

        // Sparse requests: ptr is 2 here, so grants go 3,1,3,1.
        bus.e_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            ch = (k % 2 == 0) ? 3 : 1;
            #1;
            check("rr2_e_ready", 32'(bus.e_ready), 32'(1) << ch);
            tick();
            check("rr2_s_canal", 32'(bus.s_canal), 32'(ch));
            check("rr2_s",       32'(bus.s),       32'(ch + 1));
        end

        // Backpressure holding channel 1's beat.
        bus.s_ready = 1'b0;
        bus.e_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_e_ready", 32'(bus.e_ready), 32'h0);
            tick();
            check("bp_s",       32'(bus.s),       32'h02);
            check("bp_s_canal", 32'(bus.s_canal), 32'h1);
            check("bp_s_valid", 32'(bus.s_valid), 32'h1);
        end
        bus.s_ready = 1'b1;
        #1;
        check("bp_rel_e_ready", 32'(bus.e_ready), 32'b0100);
        tick();
        check("bp_rel_s_canal", 32'(bus.s_canal), 32'h2);
        check("bp_rel_s",       32'(bus.s),       32'h03);

        // Global enable off: output drains, ptr (now 3) holds.
        bus.en = 1'b0;
        #1;
        check("en0_e_ready", 32'(bus.e_ready), 32'h0);
        tick();
        check("en0_s_valid", 32'(bus.s_valid), 32'h0);
        check("en0_s",       32'(bus.s),       32'h03);
        tick();
        check("en0_hold_valid", 32'(bus.s_valid), 32'h0);
        bus.en = 1'b1;
        #1;
        check("en1_e_ready", 32'(bus.e_ready), 32'b1000);
        tick();
        check("en1_s_canal", 32'(bus.s_canal), 32'h3);
        check("en1_s",       32'(bus.s),       32'h04);
        check("en1_s_valid", 32'(bus.s_valid), 32'h1);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_s",       32'(bus.s),       32'h00);
        check("arst_s_valid", 32'(bus.s_valid), 32'h0);
        check("arst_s_canal", 32'(bus.s_canal), 32'h0);
        check("arst_e_ready", 32'(bus.e_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_e_ready", 32'(bus.e_ready), 32'b0001);
        tick();
        check("post_rst_s_canal", 32'(bus.s_canal), 32'h0);
        check("post_rst_s",       32'(bus.s),       32'h01);

        // Switch back to fixed mode: sel=1 takes effect at the next load.
        bus.modo = 1'b0;
        bus.sel  = 2'd1;
        #1;
        check("fx2_e_ready", 32'(bus.e_ready), 32'b0010);
        tick();
        check("fx2_s_canal", 32'(bus.s_canal), 32'h1);
        check("fx2_s",       32'(bus.s),       32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
